// File: rtl/scan_pkg.sv
// Constants shared by the scan chain slots and the scan controller bench.
package scan_pkg;

   localparam int unsigned NumIosDefault = 8;
   localparam int unsigned SyncDepth     = 2;

endpackage

// File: rtl/scan_sync_edge.sv
// Synchronizer for one asynchronous scan input with a rising-edge detect.
module scan_sync_edge
   import scan_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic s0_o,
   output logic s1_o,
   output logic rise_o
);

   // The extra flop past the synchronizer holds the previous s1 for edge detection.
   logic [SyncDepth:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SyncDepth-1:0], sig_i};
      end
   end

   assign s0_o   = sync_q[0];
   assign s1_o   = sync_q[SyncDepth-1];
   assign rise_o = sync_q[SyncDepth-1] & ~sync_q[SyncDepth];

endmodule

// File: rtl/scan_slot.sv
// One scan chain slot: shifts data MSB-first, latches it onto the design
// inputs, captures design outputs and retimes the scan controls downstream.
module scan_slot
   import scan_pkg::*;
#(
   parameter int unsigned NUM_IOS = NumIosDefault
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               scan_clk_in,
   input  logic               scan_data_in,
   input  logic               scan_select_in,
   input  logic               scan_latch_en_in,
   output logic               scan_clk_out,
   output logic               scan_data_out,
   output logic               scan_select_out,
   output logic               scan_latch_en_out,
   output logic [NUM_IOS-1:0] module_data_in,
   input  logic [NUM_IOS-1:0] module_data_out,
   output logic               latch_strobe,
   output logic               frame_err
);

   localparam int unsigned CntW = (NUM_IOS > 1) ? $clog2(NUM_IOS) : 1;

   logic                 clk_s0, clk_s1, clk_rise;
   logic                 latch_s0, latch_s1, latch_rise;
   logic [SyncDepth-1:0] data_sync_q, sel_sync_q;
   logic                 data_s1, sel_s1;

   logic [NUM_IOS-1:0] shreg_q, shreg_d;
   logic [NUM_IOS-1:0] mdi_q, mdi_d;
   logic [CntW-1:0]    cnt_q, cnt_d, cnt_base;
   logic               strobe_q, strobe_d;
   logic               ferr_q, ferr_d;

   scan_sync_edge u_clk_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .sig_i  (scan_clk_in),
      .s0_o   (clk_s0),
      .s1_o   (clk_s1),
      .rise_o (clk_rise)
   );

   scan_sync_edge u_latch_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .sig_i  (scan_latch_en_in),
      .s0_o   (latch_s0),
      .s1_o   (latch_s1),
      .rise_o (latch_rise)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_sync_q <= '0;
         sel_sync_q  <= '0;
      end else begin
         data_sync_q <= {data_sync_q[SyncDepth-2:0], scan_data_in};
         sel_sync_q  <= {sel_sync_q[SyncDepth-2:0], scan_select_in};
      end
   end

   assign data_s1 = data_sync_q[SyncDepth-1];
   assign sel_s1  = sel_sync_q[SyncDepth-1];

   // s1 is exactly the registered copy of s0, so it doubles as the forwarded signal.
   logic unused_s0;
   assign unused_s0 = clk_s0 ^ latch_s0;

   always_comb begin
      shreg_d  = shreg_q;
      mdi_d    = mdi_q;
      cnt_d    = cnt_q;
      strobe_d = 1'b0;
      ferr_d   = ferr_q;

      if (latch_rise) begin
         mdi_d    = shreg_q;
         strobe_d = 1'b1;
         cnt_d    = '0;
         if (cnt_q != '0) begin
            ferr_d = 1'b1;
         end
      end

      // A shift coinciding with a latch is the first bit of the next frame.
      cnt_base = latch_rise ? '0 : cnt_q;
      if (clk_rise) begin
         if (sel_s1) begin
            shreg_d = module_data_out;
         end else begin
            shreg_d = {shreg_q[NUM_IOS-2:0], data_s1};
            cnt_d   = (cnt_base == CntW'(NUM_IOS - 1)) ? '0 : cnt_base + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q  <= '0;
         mdi_q    <= '0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         mdi_q    <= mdi_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe_d;
         ferr_q   <= ferr_d;
      end
   end

   assign scan_clk_out      = clk_s1;
   assign scan_select_out   = sel_s1;
   assign scan_latch_en_out = latch_s1;
   assign scan_data_out     = shreg_q[NUM_IOS-1];
   assign module_data_in    = mdi_q;
   assign latch_strobe      = strobe_q;
   assign frame_err         = ferr_q;

endmodule

// File: tb/tb_scan_slot.sv
// Bench for scan_slot: two chained slots driven at the pulse level and checked
// against a word-level shift/latch model.
module tb_scan_slot;
   import scan_pkg::*;

   localparam int unsigned N = NumIosDefault;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         sc_clk = 1'b0, sc_data = 1'b0, sc_sel = 1'b0, sc_latch = 1'b0;
   logic [N-1:0] mdo_a = '0, mdo_b = '0;

   logic         a_clk_out, a_data_out, a_sel_out, a_latch_out, a_strobe, a_ferr;
   logic         b_clk_out, b_data_out, b_sel_out, b_latch_out, b_strobe, b_ferr;
   logic [N-1:0] a_mdi, b_mdi;

   int checks = 0;
   int failures = 0;

   // Word-level model of both slots.
   logic [N-1:0] m_a, m_b, m_mdi_a, m_mdi_b;
   int           m_shifts;
   logic         m_ferr;

   int           lat_a, lat_b;
   logic         fwd_bit;
   logic [8:1]   strb_a, strb_b;

   always #5 clk = ~clk;

   scan_slot #(.NUM_IOS(N)) u_slot_a (
      .clk               (clk),
      .reset_n           (reset_n),
      .scan_clk_in       (sc_clk),
      .scan_data_in      (sc_data),
      .scan_select_in    (sc_sel),
      .scan_latch_en_in  (sc_latch),
      .scan_clk_out      (a_clk_out),
      .scan_data_out     (a_data_out),
      .scan_select_out   (a_sel_out),
      .scan_latch_en_out (a_latch_out),
      .module_data_in    (a_mdi),
      .module_data_out   (mdo_a),
      .latch_strobe      (a_strobe),
      .frame_err         (a_ferr)
   );

   scan_slot #(.NUM_IOS(N)) u_slot_b (
      .clk               (clk),
      .reset_n           (reset_n),
      .scan_clk_in       (a_clk_out),
      .scan_data_in      (a_data_out),
      .scan_select_in    (a_sel_out),
      .scan_latch_en_in  (a_latch_out),
      .scan_clk_out      (b_clk_out),
      .scan_data_out     (b_data_out),
      .scan_select_out   (b_sel_out),
      .scan_latch_en_out (b_latch_out),
      .module_data_in    (b_mdi),
      .module_data_out   (mdo_b),
      .latch_strobe      (b_strobe),
      .frame_err         (b_ferr)
   );

   function automatic logic [2*N+11:0] all_outs();
      return {a_clk_out, a_data_out, a_sel_out, a_latch_out, a_strobe, a_ferr, a_mdi,
              b_clk_out, b_data_out, b_sel_out, b_latch_out, b_strobe, b_ferr, b_mdi};
   endfunction

   task automatic model_clear();
      m_a = '0; m_b = '0; m_mdi_a = '0; m_mdi_b = '0; m_shifts = 0; m_ferr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      sc_clk = 1'b0; sc_data = 1'b0; sc_sel = 1'b0; sc_latch = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // One scan clock pulse (high 2, low 4); records forwarded-edge latencies and
   // the bit slot A presents at its forwarded rise.
   task automatic pulse(input logic d, input logic sel);
      @(negedge clk);
      sc_data = d;
      sc_sel  = sel;
      @(negedge clk);
      sc_clk  = 1'b1;
      lat_a   = -1;
      lat_b   = -1;
      fwd_bit = 1'bx;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         if (lat_a < 0 && a_clk_out) begin
            lat_a   = i;
            fwd_bit = a_data_out;
         end
         if (lat_b < 0 && b_clk_out) lat_b = i;
         @(negedge clk);
         if (i == 2) sc_clk = 1'b0;
      end
      if (sel) begin
         m_a = mdo_a;
         m_b = mdo_b;
      end else begin
         m_b = {m_b[N-2:0], m_a[N-1]};
         m_a = {m_a[N-2:0], d};
         m_shifts++;
      end
   endtask

   task automatic latch();
      @(negedge clk);
      sc_latch = 1'b1;
      strb_a = '0;
      strb_b = '0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         strb_a[i] = a_strobe;
         strb_b[i] = b_strobe;
         @(negedge clk);
         if (i == 2) sc_latch = 1'b0;
      end
      m_mdi_a = m_a;
      m_mdi_b = m_b;
      if (m_shifts % int'(N) != 0) m_ferr = 1'b1;
      m_shifts = 0;
   endtask

   task automatic shift_word(input logic [N-1:0] w);
      for (int i = int'(N) - 1; i >= 0; i--) pulse(w[i], 1'b0);
   endtask

   task automatic test_reset();
      logic [2*N+11:0] seen;
      reset_n = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL reset_outs: got %h want 0", all_outs());
      end
      checks++;
      @(negedge clk);
      reset_n = 1'b1;
      seen = '0;
      repeat (6) begin
         @(posedge clk);
         #1;
         seen = seen | all_outs();
      end
      if (seen !== '0) begin
         failures++;
         $display("FAIL reset_quiet: got %h want 0", seen);
      end
      checks++;
   endtask

   task automatic test_shift_latch();
      do_reset();
      shift_word(8'hA5);
      latch();
      if (a_mdi !== 8'hA5) begin
         failures++;
         $display("FAIL a5_mdi: got %h want a5", a_mdi);
      end
      checks++;
      if (strb_a !== 8'b0000_0100) begin
         failures++;
         $display("FAIL a5_strobe: got %b want 00000100", strb_a);
      end
      checks++;
      if (a_ferr !== 1'b0) begin
         failures++;
         $display("FAIL a5_ferr: got %b want 0", a_ferr);
      end
      checks++;
   endtask

   task automatic test_capture();
      logic [N-1:0] pat;
      logic         exp;
      pat = 8'b0011_1100;
      mdo_a = 8'h3C;
      pulse(1'b0, 1'b1);
      if (lat_a !== 2) begin
         failures++;
         $display("FAIL cap_fwd_latency: got %0d want 2", lat_a);
      end
      checks++;
      for (int i = 0; i < int'(N); i++) begin
         exp = m_a[N-1];
         pulse(1'b0, 1'b0);
         if (fwd_bit !== exp || fwd_bit !== pat[N-1-i]) begin
            failures++;
            $display("FAIL cap_bit%0d: got %b want %b", i, fwd_bit, pat[N-1-i]);
         end
         checks++;
      end
   endtask

   task automatic test_chain();
      logic [15:0] w;
      w = 16'h1234;
      do_reset();
      for (int i = 15; i >= 0; i--) begin
         pulse(w[i], 1'b0);
         if (i == 15) begin
            if (lat_a !== 2 || lat_b !== 4) begin
               failures++;
               $display("FAIL chain_latency: got a=%0d b=%0d want a=2 b=4", lat_a, lat_b);
            end
            checks++;
         end
      end
      latch();
      if (a_mdi !== 8'h34 || b_mdi !== 8'h12) begin
         failures++;
         $display("FAIL chain_mdi: got a=%h b=%h want a=34 b=12", a_mdi, b_mdi);
      end
      checks++;
      if (strb_a !== 8'b0000_0100 || strb_b !== 8'b0001_0000) begin
         failures++;
         $display("FAIL chain_strobe: got a=%b b=%b want a=00000100 b=00010000",
                  strb_a, strb_b);
      end
      checks++;
   endtask

   task automatic test_frame_err();
      do_reset();
      for (int i = 0; i < 5; i++) pulse(1'($urandom_range(0, 1)), 1'b0);
      latch();
      if (a_ferr !== 1'b1 || a_mdi !== m_mdi_a) begin
         failures++;
         $display("FAIL ferr_short: got ferr=%b mdi=%h want ferr=1 mdi=%h", a_ferr, a_mdi,
                  m_mdi_a);
      end
      checks++;
      shift_word(N'($urandom()));
      latch();
      if (a_ferr !== 1'b1 || a_mdi !== m_mdi_a) begin
         failures++;
         $display("FAIL ferr_sticky: got ferr=%b mdi=%h want ferr=1 mdi=%h", a_ferr, a_mdi,
                  m_mdi_a);
      end
      checks++;
   endtask

   task automatic test_reset_midframe();
      logic [2*N+11:0] seen;
      for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
      @(negedge clk);
      sc_data = 1'b1;
      @(negedge clk);
      sc_clk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      if (a_clk_out !== 1'b1) begin
         failures++;
         $display("FAIL midframe_fwd_high: got %b want 1", a_clk_out);
      end
      checks++;
      #2;
      reset_n = 1'b0;
      #1;
      if (all_outs() !== '0) begin
         failures++;
         $display("FAIL midframe_async: got %h want 0", all_outs());
      end
      checks++;
      @(negedge clk);
      sc_clk  = 1'b0;
      sc_data = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seen = '0;
      repeat (5) begin
         @(posedge clk);
         #1;
         seen = seen | all_outs();
      end
      if (seen !== '0) begin
         failures++;
         $display("FAIL midframe_no_pulse: got %h want 0", seen);
      end
      checks++;
      shift_word(8'hFF);
      latch();
      if (a_mdi !== 8'hFF || a_ferr !== 1'b0) begin
         failures++;
         $display("FAIL midframe_ff: got mdi=%h ferr=%b want mdi=ff ferr=0", a_mdi, a_ferr);
      end
      checks++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      shift_word(8'h81);
      @(negedge clk);
      sc_data = 1'b0;
      @(negedge clk);
      sc_clk   = 1'b1;
      sc_latch = 1'b1;
      repeat (2) @(negedge clk);
      sc_clk   = 1'b0;
      sc_latch = 1'b0;
      repeat (6) @(negedge clk);
      m_mdi_a = m_a;
      m_a     = {m_a[N-2:0], 1'b0};
      if (a_mdi !== 8'h81 || a_mdi !== m_mdi_a) begin
         failures++;
         $display("FAIL simul_mdi: got %h want 81", a_mdi);
      end
      checks++;
      if (a_data_out !== m_a[N-1] || a_ferr !== 1'b0) begin
         failures++;
         $display("FAIL simul_shift: got dout=%b ferr=%b want dout=%b ferr=0", a_data_out,
                  a_ferr, m_a[N-1]);
      end
      checks++;
   endtask

   task automatic test_random();
      int len;
      do_reset();
      for (int f = 0; f < 6; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            mdo_a = N'($urandom());
            mdo_b = N'($urandom());
            pulse(1'b0, 1'b1);
         end
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : int'(N);
         for (int i = 0; i < len; i++) begin
            pulse(1'($urandom_range(0, 1)), 1'b0);
            if (a_data_out !== m_a[N-1] || b_data_out !== m_b[N-1]) begin
               failures++;
               $display("FAIL rnd_dout f%0d b%0d: got a=%b b=%b want a=%b b=%b", f, i,
                        a_data_out, b_data_out, m_a[N-1], m_b[N-1]);
            end
            checks++;
         end
         latch();
         if (a_mdi !== m_mdi_a || b_mdi !== m_mdi_b) begin
            failures++;
            $display("FAIL rnd_mdi f%0d: got a=%h b=%h want a=%h b=%h", f, a_mdi, b_mdi,
                     m_mdi_a, m_mdi_b);
         end
         checks++;
         if (a_ferr !== m_ferr || b_ferr !== m_ferr) begin
            failures++;
            $display("FAIL rnd_ferr f%0d: got a=%b b=%b want %b", f, a_ferr, b_ferr, m_ferr);
         end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_shift_latch();
      test_capture();
      test_chain();
      test_frame_err();
      test_reset_midframe();
      test_simultaneous();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/scan_slot.md
# scan_slot

Per-design scan chain element, sitting directly downstream of the scan controller: one instance per tiny design, chained so each slot's forwarded outputs feed the next slot's inputs, and the last slot feeds the controller's `scan_clk_in` / `scan_data_in`. All scan signals are oversampled on the system clock. The slot does four things:
- shifts serial data MSB-first;
- latches the received word onto the design inputs;
- captures the design outputs for return;
- retimes clock, select and latch-enable toward the next slot so the data handoff between slots is race-free.

## Interface
Parameters:
- `NUM_IOS`, 8, width of the design input/output word and of the shift register.

Ports:
- `clk`  in  1  system clock; all flops on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `scan_clk_in`  in  1  scan clock from upstream (controller or previous slot); treated as asynchronous.
- `scan_data_in`  in  1  serial data from upstream.
- `scan_select_in`  in  1  1 = capture design outputs on the next scan clock rise; 0 = shift.
- `scan_latch_en_in`  in  1  rising edge transfers the shift register to the design inputs.
- `scan_clk_out`  out  1  retimed scan clock to the next slot.
- `scan_data_out`  out  1  serial data to the next slot; equals `shreg[NUM_IOS-1]`.
- `scan_select_out`  out  1  retimed select to the next slot.
- `scan_latch_en_out`  out  1  retimed latch enable to the next slot.
- `module_data_in`  out  NUM_IOS  registered inputs driven to the tiny design.
- `module_data_out`  in  NUM_IOS  outputs from the tiny design.
- `latch_strobe`  out  1  one-cycle pulse when `module_data_in` updates.
- `frame_err`  out  1  sticky; set when a latch occurs with a shift count that is not a multiple of NUM_IOS.

## Operation
Synchronizers:
- Each of the four scan inputs passes through a 2-flop synchronizer: stage `s0`, then stage `s1`.
- Clock rise detect: `s1 & ~s2` on a third flop. Latch rise detect works the same way.

On a clock rise:
- If `select_s1` = 1 (capture): `shreg <= module_data_out`.
- Otherwise (shift): `shreg <= {shreg[NUM_IOS-2:0], data_s1}` and `bit_cnt` increments.

On a latch rise:
- `module_data_in <= shreg`; `latch_strobe` pulses for 1 cycle.
- If `bit_cnt != 0` then `frame_err <= 1`. The latch is still performed.
- `bit_cnt <= 0`.

Other rules:
- `bit_cnt` is log2(NUM_IOS) bits wide and wraps modulo NUM_IOS.
- Capture does not change `bit_cnt`.
- Simultaneous clock rise and latch rise: the shift/capture and the latch both take effect; the latch uses the pre-update `shreg`.
- Bit order: the first bit shifted in lands in `module_data_in[NUM_IOS-1]`. The captured word leaves MSB first.
- Forwarding: `scan_clk_out`, `scan_select_out` and `scan_latch_en_out` are registered copies of their `s0` stages.

## Timing
- Reset: every flop, and therefore every output, is 0. `frame_err` is cleared only by reset. Asserting reset mid-frame discards partial shifts immediately; no pulse is emitted after release until a new input edge arrives.
- Input-to-forward latency: 2 cycles.
  - `scan_clk_in` first sampled high in cycle 0 → `scan_clk_out` high in cycle 2.
  - `shreg` / `scan_data_out` update in cycle 3.
  - The forwarded clock therefore rises one cycle before this slot's data changes. The next slot samples `data_s1` at its detect, which still holds the old value. This is the required race-free chain behaviour.
- Minimum input pulse: high ≥1 cycle, low ≥1 cycle.
- Select and latch enable must be stable for ≥1 cycle before the scan clock rise they qualify. All retimed signals share the same 2-cycle delay, so this relationship is preserved down the chain.
- `latch_strobe` and the `module_data_in` update occur 3 cycles after `scan_latch_en_in` rises.

## Structure
- Shared package `scan_pkg`: `NUM_IOS` default and the synchronizer depth constant (2), also used by the scan controller bench.
- Sub-module `scan_sync_edge`: synchronizer plus rise detect, exporting `s0`, `s1` and `rise`. Instantiate it for clock and latch enable; data and select use only its synchronizer outputs.

## Test plan
- Shift 0xA5 (8 pulses, MSB first), then latch → `module_data_in` = 0xA5; `latch_strobe` high exactly 1 cycle, 3 cycles after the latch rise; `frame_err` = 0.
- `module_data_out` = 0x3C; select=1 with one clock pulse, then 8 shift pulses → `scan_data_out` sampled at each forwarded clock rise reads 0,0,1,1,1,1,0,0.
- Two slots chained, 16 bits 0x12 then 0x34 shifted, then latch → slot A `module_data_in` = 0x34, slot B = 0x12; each forwarded edge is delayed 2 cycles per slot.
- 5 shifts then latch → `frame_err` = 1 and stays 1 after a subsequent correct 8-bit frame; `module_data_in` still updated.
- Drive `reset_n` low after 4 shifts → all outputs 0 immediately. After release, a full 8-bit 0xFF frame latches 0xFF with `frame_err` = 0.
- Clock rise and latch rise in the same cycle, with `shreg` = 0x81 → `module_data_in` = 0x81, and `shreg` shifts.
